mod8_counter_monitor: RTL and testbench

MOD8_COUNTER_MONITOR -- requirements
Module: mod8_counter_monitor

---
 rtl/mod8_counter_monitor.sv | 115 +++++++++++
 tb/tb_mod8_counter_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mod8_counter_monitor.sv
// Watches a mod-8 up/down counter and locks once its transitions are consistently correct.
// Latency: every output is registered and updates one CP edge after the sample that caused it.
// Backpressure: none; one sample is accepted per cycle and clr is applied on the next edge.
module mod8_counter_monitor #(
    parameter int LOCK_LEN = 2,
    parameter int CNT_W    = 8
) (
    input  logic             CP,
    input  logic             reset,
    input  logic             ctr_reset,
    input  logic             M,
    input  logic [3:0]       Q,
    input  logic             Qcc_n,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {SYNC, ACQ, TRACK} state_t;

    localparam logic [3:0] LOCK_LEN_V = 4'(LOCK_LEN);

    state_t     state;
    logic [3:0] mc;
    logic [2:0] q_p;
    logic       m_p;
    logic       r_p;

    logic [2:0] exp_q;
    logic       exp_cc_n;
    logic       good;
    logic       wrap_hit;
    logic       violation;
    logic       wrap_evt;

    always_comb begin
        exp_q = 3'd0;
        if (!r_p) exp_q = m_p ? (q_p + 3'd1) : (q_p - 3'd1);
        exp_cc_n  = !((M && Q == 4'd7) || (!M && Q == 4'd0));
        good      = !Q[3] && (Q[2:0] == exp_q) && (Qcc_n == exp_cc_n);
        // A counter reset landing on 0 is never a wrap, even from 7.
        wrap_hit  = good && !r_p &&
                    ((m_p && q_p == 3'd7 && Q[2:0] == 3'd0) ||
                     (!m_p && q_p == 3'd0 && Q[2:0] == 3'd7));
        violation = (state == TRACK) && !good;
        wrap_evt  = (state == TRACK) && wrap_hit;
    end

    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            state      <= SYNC;
            mc         <= 4'd0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
            q_p        <= 3'd0;
            m_p        <= 1'b1;
            r_p        <= 1'b1;
        end else begin
            q_p <= Q[2:0];
            m_p <= M;
            r_p <= ctr_reset;
            err <= violation;

            case (state)
                SYNC: begin
                    state <= ACQ;
                    mc    <= 4'd0;
                end
                ACQ: begin
                    if (!good) begin
                        mc <= 4'd0;
                    end else if (mc + 4'd1 == LOCK_LEN_V) begin
                        state  <= TRACK;
                        locked <= 1'b1;
                        mc     <= 4'd0;
                    end else begin
                        mc <= mc + 4'd1;
                    end
                end
                TRACK: begin
                    if (!good) begin
                        state  <= ACQ;
                        mc     <= 4'd0;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= SYNC;
                    mc     <= 4'd0;
                    locked <= 1'b0;
                end
            endcase

            // A same-cycle event takes precedence over clr, so the count restarts at 1.
            if (violation) begin
                err_sticky <= 1'b1;
                if (clr)               err_cnt <= CNT_W'(1);
                else if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end else if (clr) begin
                err_sticky <= 1'b0;
                err_cnt    <= '0;
            end

            if (wrap_evt)  wrap_cnt <= clr ? CNT_W'(1) : wrap_cnt + CNT_W'(1);
            else if (clr)  wrap_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mod8_counter_monitor.sv
// Directed table of counter samples with hand-computed monitor outputs, plus
// saturation and asynchronous-reset sequences.
module tb_mod8_counter_monitor;

    logic       CP = 1'b0;
    logic       reset;
    logic       ctr_reset;
    logic       M;
    logic [3:0] Q;
    logic       Qcc_n;
    logic       clr;
    logic       locked;
    logic       err;
    logic       err_sticky;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mod8_counter_monitor #(.LOCK_LEN(2), .CNT_W(8)) dut (
        .CP(CP), .reset(reset), .ctr_reset(ctr_reset), .M(M), .Q(Q),
        .Qcc_n(Qcc_n), .clr(clr), .locked(locked), .err(err),
        .err_sticky(err_sticky), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
    );

    always #5 CP = ~CP;

    typedef struct {
        logic       r;
        logic       m;
        logic [3:0] q;
        logic       cc;
        logic       c;
        logic       lk;
        logic       er;
        logic       st;
        int         ec;
        int         wc;
    } vec_t;

    vec_t tbl[58];

    function automatic vec_t mk(logic r, logic m, logic [3:0] q, logic cc, logic c,
                                logic lk, logic er, logic st, int ec, int wc);
        vec_t v;
        v.r = r; v.m = m; v.q = q; v.cc = cc; v.c = c;
        v.lk = lk; v.er = er; v.st = st; v.ec = ec; v.wc = wc;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [3:0] q,
                         input logic cc, input logic c);
        ctr_reset = r; M = m; Q = q; Qcc_n = cc; clr = c;
        @(posedge CP);
        #1;
    endtask

    task automatic chk_all(input string tag, input int lk, input int er,
                           input int st, input int ec, input int wc);
        chk({tag, " locked"}, int'(locked), lk);
        chk({tag, " err"}, int'(err), er);
        chk({tag, " err_sticky"}, int'(err_sticky), st);
        chk({tag, " err_cnt"}, int'(err_cnt), ec);
        chk({tag, " wrap_cnt"}, int'(wrap_cnt), wc);
    endtask

    initial begin
        int pulses;
        //              r  m  q  cc clr  lk er st ec wc
        tbl[0]  = mk(0, 1, 0, 1, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 1, 0,  0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 2, 1, 0,  1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 3, 1, 0,  1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 4, 1, 0,  1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 5, 1, 0,  1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 6, 1, 0,  1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 7, 0, 0,  1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 1, 0,  1, 0, 0, 0, 1);
        tbl[9]  = mk(0, 1, 1, 1, 0,  1, 0, 0, 0, 1);
        tbl[10] = mk(0, 1, 2, 1, 0,  1, 0, 0, 0, 1);
        tbl[11] = mk(0, 1, 3, 1, 0,  1, 0, 0, 0, 1);
        tbl[12] = mk(0, 1, 4, 1, 0,  1, 0, 0, 0, 1);
        tbl[13] = mk(0, 1, 5, 1, 0,  1, 0, 0, 0, 1);
        // direction change: 5,6,5,4 with the 5->6 step checked against the old mode
        tbl[14] = mk(0, 0, 6, 1, 0,  1, 0, 0, 0, 1);
        tbl[15] = mk(0, 0, 5, 1, 0,  1, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 4, 1, 0,  1, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 3, 1, 0,  1, 0, 0, 0, 1);
        tbl[18] = mk(0, 0, 2, 1, 0,  1, 0, 0, 0, 1);
        tbl[19] = mk(0, 0, 1, 1, 0,  1, 0, 0, 0, 1);
        tbl[20] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1);
        tbl[21] = mk(0, 0, 7, 1, 0,  1, 0, 0, 0, 2);
        tbl[22] = mk(0, 0, 6, 1, 0,  1, 0, 0, 0, 2);
        tbl[23] = mk(0, 1, 5, 1, 0,  1, 0, 0, 0, 2);
        // Q=3 where 6 is expected, then relock after two good steps
        tbl[24] = mk(0, 1, 3, 1, 0,  0, 1, 1, 1, 2);
        tbl[25] = mk(0, 1, 4, 1, 0,  0, 0, 1, 1, 2);
        tbl[26] = mk(0, 1, 5, 1, 0,  1, 0, 1, 1, 2);
        tbl[27] = mk(0, 1, 6, 1, 0,  1, 0, 1, 1, 2);
        tbl[28] = mk(0, 1, 7, 0, 0,  1, 0, 1, 1, 2);
        tbl[29] = mk(0, 1, 0, 1, 0,  1, 0, 1, 1, 3);
        tbl[30] = mk(0, 1, 1, 1, 0,  1, 0, 1, 1, 3);
        tbl[31] = mk(0, 1, 2, 1, 0,  1, 0, 1, 1, 3);
        tbl[32] = mk(0, 1, 3, 1, 0,  1, 0, 1, 1, 3);
        // ctr_reset held two cycles at Q=4
        tbl[33] = mk(1, 1, 4, 1, 0,  1, 0, 1, 1, 3);
        tbl[34] = mk(1, 1, 0, 1, 0,  1, 0, 1, 1, 3);
        tbl[35] = mk(0, 1, 0, 1, 0,  1, 0, 1, 1, 3);
        tbl[36] = mk(0, 1, 1, 1, 0,  1, 0, 1, 1, 3);
        tbl[37] = mk(0, 1, 2, 1, 0,  1, 0, 1, 1, 3);
        tbl[38] = mk(0, 1, 3, 1, 0,  1, 0, 1, 1, 3);
        tbl[39] = mk(0, 1, 4, 1, 0,  1, 0, 1, 1, 3);
        tbl[40] = mk(0, 1, 5, 1, 0,  1, 0, 1, 1, 3);
        tbl[41] = mk(0, 1, 6, 1, 0,  1, 0, 1, 1, 3);
        // counter reset from 7 lands on 0 but is not a wrap
        tbl[42] = mk(1, 1, 7, 0, 0,  1, 0, 1, 1, 3);
        tbl[43] = mk(0, 1, 0, 1, 0,  1, 0, 1, 1, 3);
        tbl[44] = mk(0, 1, 1, 1, 0,  1, 0, 1, 1, 3);
        tbl[45] = mk(0, 1, 2, 0, 0,  0, 1, 1, 2, 3);
        tbl[46] = mk(0, 1, 3, 1, 0,  0, 0, 1, 2, 3);
        tbl[47] = mk(0, 1, 4, 1, 0,  1, 0, 1, 2, 3);
        // both Q and Qcc_n wrong: a single err
        tbl[48] = mk(0, 1, 6, 0, 0,  0, 1, 1, 3, 3);
        tbl[49] = mk(0, 1, 7, 0, 0,  0, 0, 1, 3, 3);
        tbl[50] = mk(0, 1, 0, 1, 0,  1, 0, 1, 3, 3);
        tbl[51] = mk(0, 1, 1, 1, 0,  1, 0, 1, 3, 3);
        // clr coinciding with a violation, then clr in ACQ and in TRACK
        tbl[52] = mk(0, 1, 5, 1, 1,  0, 1, 1, 1, 0);
        tbl[53] = mk(0, 1, 6, 1, 1,  0, 0, 0, 0, 0);
        tbl[54] = mk(0, 1, 7, 0, 0,  1, 0, 0, 0, 0);
        tbl[55] = mk(0, 1, 0, 1, 0,  1, 0, 0, 0, 1);
        tbl[56] = mk(0, 1, 1, 1, 1,  1, 0, 0, 0, 0);
        tbl[57] = mk(0, 1, 2, 1, 0,  1, 0, 0, 0, 0);

        reset = 1'b0; ctr_reset = 1'b0; M = 1'b1; Q = 4'd0; Qcc_n = 1'b1; clr = 1'b0;
        repeat (2) @(posedge CP);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < 58; i++) begin
            drive(tbl[i].r, tbl[i].m, tbl[i].q, tbl[i].cc, tbl[i].c);
            chk_all($sformatf("row%0d", i), int'(tbl[i].lk), int'(tbl[i].er),
                    int'(tbl[i].st), tbl[i].ec, tbl[i].wc);
        end

        // 300 relock-then-violate rounds with Qcc_n stuck high at Q=7
        pulses = 0;
        for (int i = 1; i <= 300; i++) begin
            for (int q = 3; q <= 6; q++) begin
                drive(0, 1, 4'(q), 1, 0);
                if (err) pulses++;
            end
            drive(0, 1, 4'd7, 1, 0);
            if (err) pulses++;
            if (i == 254) chk("sat err_cnt 254", int'(err_cnt), 254);
            if (i == 255) chk("sat err_cnt 255", int'(err_cnt), 255);
            if (i == 300) chk("sat err pulse 300", int'(err), 1);
            drive(0, 1, 4'd0, 1, 0);
            if (err) pulses++;
            drive(0, 1, 4'd1, 1, 0);
            if (err) pulses++;
            drive(0, 1, 4'd2, 1, 0);
            if (err) pulses++;
        end
        chk("sat pulse count", pulses, 300);
        chk("sat err_cnt held", int'(err_cnt), 255);
        chk("sat sticky", int'(err_sticky), 1);
        chk("sat locked", int'(locked), 1);
        drive(0, 1, 4'd3, 1, 1);
        chk_all("clean clr", 1, 0, 0, 0, 0);

        // Q=8 violation followed by an asynchronous reset mid-cycle
        drive(0, 1, 4'd8, 1, 0);
        chk_all("q8", 0, 1, 1, 1, 0);
        #3;
        reset = 1'b0;
        #1;
        chk_all("async reset", 0, 0, 0, 0, 0);
        repeat (2) @(posedge CP);
        #1;
        chk_all("reset held", 0, 0, 0, 0, 0);
        reset = 1'b1;
        drive(0, 1, 4'd0, 1, 0);
        chk("post reset sync locked", int'(locked), 0);
        drive(0, 1, 4'd1, 1, 0);
        drive(0, 1, 4'd2, 1, 0);
        chk_all("post reset relock", 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
